// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: op encoding and RAS error bit positions.
package pc_pkg;

  typedef enum logic [2:0] {
    NEXT   = 3'd0,
    JUMP   = 3'd1,
    BRANCH = 3'd2,
    CALL   = 3'd3,
    RET    = 3'd4
  } pc_op_t;

  // Bit positions inside the sticky {overflow, underflow} error vector
  localparam int unsigned RAS_ERR_OVF = 1;
  localparam int unsigned RAS_ERR_UNF = 0;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO, a push while full overwrites the oldest entry.
// A pop while empty leaves the pointer and count untouched.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_data,
  output logic [AW-1:0] o_data,
  output logic          o_empty,
  output logic          o_full
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW + 1)'(RAS_DEPTH);

  logic [AW-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0] r_top;  // next free slot; top entry sits at r_top-1
  logic [PW:0]   r_cnt;
  logic [PW-1:0] w_top_m1;

  assign w_top_m1 = r_top - PW'(1);
  assign o_data   = r_mem[w_top_m1];
  assign o_empty  = (r_cnt == '0);
  assign o_full   = (r_cnt == CNT_MAX);

  // Storage write; the pointer wraps so a push when full lands on the oldest entry
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_push) begin
      r_mem[r_top] <= i_data;
    end
  end

  // Pointer and occupancy update; count saturates at RAS_DEPTH
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_top <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_top <= r_top + PW'(1);
      if (!o_full) begin
        r_cnt <= r_cnt + (PW + 1)'(1);
      end
    end else if (i_pop && !o_empty) begin
      r_top <= w_top_m1;
      r_cnt <= r_cnt - (PW + 1)'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC mux, PC register, return-address stack and sticky RAS errors.
// Optional feature macro PC_TRAP_EN adds a trap input and an exception-PC output.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned TRAP_VEC  = 'hF0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
  input  logic [2:0]    i_op,
  input  logic          i_cond,
  input  logic [AW-1:0] i_target,
  input  logic [AW-1:0] i_offset,
  output logic [AW-1:0] o_pc,
  output logic [AW-1:0] o_pc_next,
  output logic          o_ras_empty,
  output logic          o_ras_full,
  output logic [1:0]    o_ras_err
`ifdef PC_TRAP_EN
  ,
  input  logic          i_trap,
  output logic [AW-1:0] o_epc
`endif
);

  localparam logic [AW-1:0] STEP_W  = AW'(STEP);
  localparam logic [AW-1:0] RESET_W = AW'(RESET_VEC);
  localparam logic [AW-1:0] TRAP_W  = AW'(TRAP_VEC);

  logic [AW-1:0] r_pc;
  logic [1:0]    r_ras_err;
  logic [AW-1:0] w_pc_next;
  logic [AW-1:0] w_seq;
  logic [AW-1:0] w_ras_data;
  logic          w_trap;
  logic          w_op_act;  // an op (not stall, not trap) is taken this cycle
  logic          w_push;
  logic          w_pop;

`ifdef PC_TRAP_EN
  logic [AW-1:0] r_epc;
  assign w_trap = i_trap;
  assign o_epc  = r_epc;

  // Capture the interrupted PC when a trap is taken
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_epc <= '0;
    end else if (i_run && i_trap) begin
      r_epc <= r_pc;
    end
  end
`else
  assign w_trap = 1'b0;
`endif

  assign w_seq    = r_pc + STEP_W;
  assign w_op_act = i_run && !w_trap && !i_rst;
  assign w_push   = w_op_act && (i_op == CALL);
  assign w_pop    = w_op_act && (i_op == RET) && !o_ras_empty;

  pc_ras #(
    .AW       (AW),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (w_seq),
    .o_data (w_ras_data),
    .o_empty(o_ras_empty),
    .o_full (o_ras_full)
  );

  // Next-PC selection; stall holds, trap outranks op, unknown op codes step sequentially
  always_comb begin
    w_pc_next = r_pc;
    if (i_run) begin
      if (w_trap) begin
        w_pc_next = TRAP_W;
      end else begin
        case (i_op)
          JUMP:    w_pc_next = i_target;
          BRANCH:  w_pc_next = i_cond ? (r_pc + i_offset) : w_seq;
          CALL:    w_pc_next = i_target;
          RET:     w_pc_next = o_ras_empty ? w_seq : w_ras_data;
          default: w_pc_next = w_seq;
        endcase
      end
    end
  end

  // PC register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RESET_W;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Sticky RAS error flags, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ras_err <= 2'b00;
    end else if (w_op_act) begin
      if (i_op == CALL && o_ras_full) begin
        r_ras_err[RAS_ERR_OVF] <= 1'b1;
      end
      if (i_op == RET && o_ras_empty) begin
        r_ras_err[RAS_ERR_UNF] <= 1'b1;
      end
    end
  end

  assign o_pc      = r_pc;
  assign o_pc_next = w_pc_next;
  assign o_ras_err = r_ras_err;

endmodule
